// File: rtl/dcache_wb_param_if.sv
// dcache_wb_param_if: CPU-side and memory-side bus of the write-back data cache.
//   CPU side   : address, data_in_cpu, rd, wr (byte enables), flush,
//                data2cpu, data_ready, waiting, flush_done
//   Memory side: m_rd_address, mrden, data_in_mem, m_wr_address, mwren, data2mem
//   DCACHE_PERF_CNT_EN adds hit_cnt / miss_cnt / wb_cnt (cache-driven).
// Modports: slave = the cache, master = the pipeline/memory side.
interface dcache_wb_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   data_in_cpu;
  logic                rd;
  logic [DATA_W/8-1:0] wr;
  logic                flush;
  logic [DATA_W-1:0]   data2cpu;
  logic                data_ready;
  logic                waiting;
  logic                flush_done;
  logic [ADDR_W-1:0]   m_rd_address;
  logic                mrden;
  logic [DATA_W-1:0]   data_in_mem;
  logic [ADDR_W-1:0]   m_wr_address;
  logic [DATA_W/8-1:0] mwren;
  logic [DATA_W-1:0]   data2mem;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]         hit_cnt;
  logic [31:0]         miss_cnt;
  logic [31:0]         wb_cnt;

  modport slave (
    input  address, data_in_cpu, rd, wr, flush, data_in_mem,
    output data2cpu, data_ready, waiting, flush_done,
           m_rd_address, mrden, m_wr_address, mwren, data2mem,
           hit_cnt, miss_cnt, wb_cnt
  );
  modport master (
    output address, data_in_cpu, rd, wr, flush, data_in_mem,
    input  data2cpu, data_ready, waiting, flush_done,
           m_rd_address, mrden, m_wr_address, mwren, data2mem,
           hit_cnt, miss_cnt, wb_cnt
  );
`else
  modport slave (
    input  address, data_in_cpu, rd, wr, flush, data_in_mem,
    output data2cpu, data_ready, waiting, flush_done,
           m_rd_address, mrden, m_wr_address, mwren, data2mem
  );
  modport master (
    output address, data_in_cpu, rd, wr, flush, data_in_mem,
    input  data2cpu, data_ready, waiting, flush_done,
           m_rd_address, mrden, m_wr_address, mwren, data2mem
  );
`endif
endinterface

// File: rtl/dcache_wb_param.sv
// dcache_wb_param: write-back, write-allocate, direct-mapped data cache.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : dcache_wb_param_if.slave (CPU request/response + memory port)
// Misses evict a dirty victim in WORDS_PER_LINE write cycles, then burst-fill
// the line (one read per cycle, data MEM_RD_LAT cycles later), then replay the
// held request in DONE. flush walks all lines, writing back dirty ones.
// Optional macro DCACHE_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module dcache_wb_param #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_RD_LAT     = 1
) (
  input logic              clk,
  input logic              rst,
  dcache_wb_param_if.slave bus
);
  localparam int BE_W  = DATA_W/8;
  localparam int OFF   = $clog2(BE_W);
  localparam int WOFF  = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF - WOFF - IDX;
  localparam int CW    = $clog2(WORDS_PER_LINE + MEM_RD_LAT) + 1;
  localparam logic [CW-1:0]  WB_LAST   = CW'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0]  FILL_LAST = CW'(WORDS_PER_LINE + MEM_RD_LAT - 1);
  localparam logic [CW-1:0]  N_WORDS   = CW'(WORDS_PER_LINE);
  localparam logic [CW-1:0]  RD_LAT    = CW'(MEM_RD_LAT);
  localparam logic [IDX-1:0] LAST_LINE = IDX'(NUM_LINES - 1);

  typedef enum logic [2:0] {IDLE, WB, FILL, DONE, FLUSH} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;        // word counter in WB/FLUSH, issue/capture counter in FILL
  logic [IDX-1:0]       fl_line;
  logic                 flush_pend;
  logic                 flush_done_q;
  logic [DATA_W-1:0]    data2cpu_q;
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    line_q [NUM_LINES][WORDS_PER_LINE];

  // request held across a miss
  logic [TAG_W-1:0]  r_tag;
  logic [IDX-1:0]    r_idx;
  logic [WOFF-1:0]   r_word;
  logic [DATA_W-1:0] r_data;
  logic              r_rd;
  logic [BE_W-1:0]   r_wr;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX-1:0]    a_idx, c_idx, wb_line;
  logic [WOFF-1:0]   a_word, c_word, cap_word;
  logic [DATA_W-1:0] c_data, c_old;
  logic [BE_W-1:0]   c_wr;
  logic              req, hit, idle_hit, idle_miss, idle_flush, in_done;
  logic              c_rd, c_ld, complete, fl_dirty, wb_act, fill_iss, fill_cap, fill_last;
  logic              addr_unused;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign a_tag       = bus.address[ADDR_W-1 -: TAG_W];
  assign a_idx       = bus.address[OFF+WOFF +: IDX];
  assign a_word      = bus.address[OFF +: WOFF];
  assign addr_unused = ^bus.address[OFF-1:0];

  assign req        = bus.rd || (bus.wr != '0);
  assign hit        = valid[a_idx] && (tag_q[a_idx] == a_tag);
  assign idle_hit   = (state == IDLE) && req && hit;
  assign idle_miss  = (state == IDLE) && req && !hit;
  assign idle_flush = (state == IDLE) && !req && (bus.flush || flush_pend);
  assign in_done    = (state == DONE);

  // completing access: live inputs on an IDLE hit, held request in DONE
  assign c_idx    = in_done ? r_idx  : a_idx;
  assign c_word   = in_done ? r_word : a_word;
  assign c_data   = in_done ? r_data : bus.data_in_cpu;
  assign c_wr     = in_done ? r_wr   : bus.wr;
  assign c_rd     = in_done ? r_rd   : bus.rd;
  assign c_ld     = c_rd && (c_wr == '0);
  assign c_old    = line_q[c_idx][c_word];
  assign complete = idle_hit || in_done;

  assign fl_dirty  = valid[fl_line] && dirty[fl_line];
  assign wb_act    = (state == WB) || ((state == FLUSH) && fl_dirty);
  assign wb_line   = (state == WB) ? r_idx : fl_line;
  assign fill_iss  = (state == FILL) && (cnt < N_WORDS);
  assign fill_cap  = (state == FILL) && (cnt >= RD_LAT);
  assign fill_last = (state == FILL) && (cnt == FILL_LAST);
  assign cap_word  = WOFF'(cnt - RD_LAT);

  assign bus.data_ready   = complete;
  assign bus.data2cpu     = (complete && c_ld) ? c_old : data2cpu_q;
  assign bus.waiting      = idle_miss || idle_flush || (state == WB) ||
                            (state == FILL) || (state == FLUSH);
  assign bus.flush_done   = flush_done_q;
  assign bus.mrden        = fill_iss;
  assign bus.m_rd_address = fill_iss ? {r_tag, r_idx, cnt[WOFF-1:0], {OFF{1'b0}}} : '0;
  assign bus.mwren        = {BE_W{wb_act}};
  assign bus.m_wr_address = wb_act ? {tag_q[wb_line], wb_line, cnt[WOFF-1:0], {OFF{1'b0}}} : '0;
  assign bus.data2mem     = wb_act ? line_q[wb_line][cnt[WOFF-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      fl_line      <= '0;
      flush_pend   <= 1'b0;
      flush_done_q <= 1'b0;
      data2cpu_q   <= '0;
      valid        <= '0;
      dirty        <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_data       <= '0;
      r_rd         <= 1'b0;
      r_wr         <= '0;
    end else begin
      flush_done_q <= 1'b0;
      if (complete && c_ld) data2cpu_q <= c_old;
      case (state)
        IDLE: begin
          // a flush raised alongside a request is remembered and run afterwards
          if (req && bus.flush) flush_pend <= 1'b1;
          if (idle_hit) begin
            if (bus.wr != '0) dirty[a_idx] <= 1'b1;
          end else if (idle_miss) begin
            r_tag  <= a_tag;
            r_idx  <= a_idx;
            r_word <= a_word;
            r_data <= bus.data_in_cpu;
            r_rd   <= bus.rd;
            r_wr   <= bus.wr;
            cnt    <= '0;
            state  <= (valid[a_idx] && dirty[a_idx]) ? WB : FILL;
          end else if (idle_flush) begin
            flush_pend <= 1'b0;
            fl_line    <= '0;
            cnt        <= '0;
            state      <= FLUSH;
          end
        end
        WB: begin
          if (cnt == WB_LAST) begin
            cnt   <= '0;
            state <= FILL;
          end else cnt <= cnt + CW'(1);
        end
        FILL: begin
          if (fill_last) begin
            valid[r_idx] <= 1'b1;
            dirty[r_idx] <= 1'b0;
            state        <= DONE;
          end else cnt <= cnt + CW'(1);
        end
        DONE: begin
          if (r_wr != '0) dirty[r_idx] <= 1'b1;
          state <= IDLE;
        end
        FLUSH: begin
          if (fl_dirty && (cnt != WB_LAST)) cnt <= cnt + CW'(1);
          else begin
            cnt            <= '0;
            valid[fl_line] <= 1'b0;
            dirty[fl_line] <= 1'b0;
            if (fl_line == LAST_LINE) begin
              flush_done_q <= 1'b1;
              state        <= IDLE;
            end else fl_line <= fl_line + IDX'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // data/tag arrays carry no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (fill_cap)  line_q[r_idx][cap_word] <= bus.data_in_mem;
    if (fill_last) tag_q[r_idx] <= r_tag;
    if (complete && (c_wr != '0)) line_q[c_idx][c_word] <= merge(c_old, c_data, c_wr);
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_q, miss_q, wbc_q;
  logic        wb_line_done;
  assign wb_line_done = wb_act && (cnt == WB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
      wbc_q  <= '0;
    end else begin
      if (idle_hit     && (hit_q  != '1)) hit_q  <= hit_q  + 32'd1;
      if (idle_miss    && (miss_q != '1)) miss_q <= miss_q + 32'd1;
      if (wb_line_done && (wbc_q  != '1)) wbc_q  <= wbc_q  + 32'd1;
    end
  end

  assign bus.hit_cnt  = hit_q;
  assign bus.miss_cnt = miss_q;
  assign bus.wb_cnt   = wbc_q;
`endif
endmodule

// File: tb/tb_dcache_wb_param.sv
// Bench for dcache_wb_param at default parameters: directed vector table,
// hand sequences for eviction / flush / reset-mid-fill, then random traffic
// checked against a line-state + flat-memory reference model.
module tb_dcache_wb_param;
  localparam int AW = 32, DW = 64, NL = 16, WPL = 4, LAT = 1, BW = DW/8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_wb_param_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dcache_wb_param #(.ADDR_W(AW), .DATA_W(DW), .NUM_LINES(NL),
                    .WORDS_PER_LINE(WPL), .MEM_RD_LAT(LAT))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, failures = 0;

  function automatic logic [DW-1:0] bmerge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [int unsigned];
  logic [DW-1:0] rd_pipe [LAT];
  int unsigned   rd_log[$], wr_log[$];
  int            both_cnt = 0;

  function automatic logic [DW-1:0] init_val(input logic [31:0] a);
    return (a == 32'h100) ? 64'hA5 : {~a, a};
  endfunction
  function automatic logic [DW-1:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  assign bus.data_in_mem = rd_pipe[LAT-1];
  always @(posedge clk) begin
    if (bus.mrden) rd_log.push_back(bus.m_rd_address);
    if (bus.mwren != '0) begin
      wr_log.push_back(bus.m_wr_address);
      mem[bus.m_wr_address] = bmerge(mem_rd(bus.m_wr_address), bus.data2mem, bus.mwren);
    end
    if (bus.mrden && (bus.mwren != '0)) both_cnt++;
    rd_pipe[0] <= mem_rd(bus.m_rd_address);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // ---------------- reference model ----------------
  bit            rv[NL], rdty[NL];
  int unsigned   rtag[NL];
  logic [DW-1:0] view [int unsigned];   // what the CPU should observe at each word

  function automatic logic [DW-1:0] view_rd(input logic [31:0] a);
    return view.exists(a) ? view[a] : init_val(a);
  endfunction

  // returns expected waiting cycles for an access and updates line state
  function automatic int ref_access(input logic [31:0] a, input bit st);
    int unsigned ln, idx, tg;
    int w;
    ln  = a / (BW*WPL);
    idx = ln % NL;
    tg  = ln / NL;
    if (rv[idx] && rtag[idx] == tg) begin
      w = 0;
      rdty[idx] = rdty[idx] | st;
    end else begin
      w = WPL + LAT + 1 + ((rv[idx] && rdty[idx]) ? WPL : 0);
      rv[idx] = 1'b1; rtag[idx] = tg; rdty[idx] = st;
    end
    return w;
  endfunction

  function automatic int ref_dirty_lines();
    int n = 0;
    for (int i = 0; i < NL; i++) if (rv[i] && rdty[i]) n++;
    return n;
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < NL; i++) begin rv[i] = 1'b0; rdty[i] = 1'b0; end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_ready"}, 64'(bus.data_ready), 0);
    chk({tag, "_waiting"},    64'(bus.waiting), 0);
    chk({tag, "_flush_done"}, 64'(bus.flush_done), 0);
    chk({tag, "_data2cpu"},   bus.data2cpu, 0);
    chk({tag, "_mrden"},      64'(bus.mrden), 0);
    chk({tag, "_m_rd_addr"},  64'(bus.m_rd_address), 0);
    chk({tag, "_mwren"},      64'(bus.mwren), 0);
    chk({tag, "_m_wr_addr"},  64'(bus.m_wr_address), 0);
    chk({tag, "_data2mem"},   bus.data2mem, 0);
  endtask

  // Entered at posedge+1. Presents a request, counts waiting cycles until
  // data_ready, then drops the request after the completing edge.
  task automatic do_req(input logic [31:0] a, input bit ld, input logic [BW-1:0] be,
                        input logic [DW-1:0] d, output logic [DW-1:0] rdata,
                        output int wcyc, output bit done, output bit wt_at_done);
    bus.address = a; bus.rd = ld; bus.wr = ld ? '0 : be; bus.data_in_cpu = d;
    #1;
    wcyc = 0; done = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.data_ready) begin done = 1; break; end
      if (bus.waiting) wcyc++;
      @(posedge clk); #2;
    end
    rdata = bus.data2cpu;
    wt_at_done = bus.waiting;
    if (!ld) view[a] = bmerge(view_rd(a), d, be);
    @(posedge clk); #1;
    bus.rd = 1'b0; bus.wr = '0;
  endtask

  task automatic do_flush(output bit seen, output int nmw);
    int w0;
    w0 = wr_log.size();
    seen = 0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.flush_done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    nmw = wr_log.size() - w0;
    @(posedge clk); #1;
    chk("flush_done_one_cycle", 64'(bus.flush_done), 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          ld;
    logic [7:0]  be;
    logic [63:0] d;
    logic [63:0] exp_d;
    int          exp_wait;
    int          exp_mr;
    int          exp_mw;
  } vec_t;

  initial begin
    vec_t          tbl[5];
    logic [DW-1:0] rdata;
    int            wcyc, mr0, mw0, rb0, rb4, wb4, nmw, ew;
    bit            done, wt, seen, ld;
    logic [31:0]   a;
    logic [7:0]    be;
    logic [63:0]   d;

    tbl[0] = '{32'h100, 1, 8'h00, 64'h0, 64'h00000000_000000A5, 6, 4, 0};
    tbl[1] = '{32'h108, 1, 8'h00, 64'h0, 64'hFFFFFEF7_00000108, 0, 0, 0};
    tbl[2] = '{32'h100, 0, 8'h0F, 64'h11223344_55667788, 64'h0, 0, 0, 0};
    tbl[3] = '{32'h100, 1, 8'h00, 64'h0, 64'h00000000_55667788, 0, 0, 0};
    tbl[4] = '{32'h500, 1, 8'h00, 64'h0, 64'hFFFFFAFF_00000500, 10, 4, 4};

    bus.address = '0; bus.data_in_cpu = '0; bus.rd = 1'b0; bus.wr = '0; bus.flush = 1'b0;
    ref_clear();
    #12;
    chk_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ---- directed table ----
    rb0 = 0; rb4 = 0; wb4 = 0;
    for (int i = 0; i < 5; i++) begin
      mr0 = rd_log.size(); mw0 = wr_log.size();
      if (i == 0) rb0 = mr0;
      if (i == 4) begin rb4 = mr0; wb4 = mw0; end
      void'(ref_access(tbl[i].addr, !tbl[i].ld));
      do_req(tbl[i].addr, tbl[i].ld, tbl[i].be, tbl[i].d, rdata, wcyc, done, wt);
      chk($sformatf("vec%0d_ready", i), 64'(done), 1);
      chk($sformatf("vec%0d_wait", i), 64'(wcyc), 64'(tbl[i].exp_wait));
      chk($sformatf("vec%0d_wait_at_ready", i), 64'(wt), 0);
      if (tbl[i].ld) chk($sformatf("vec%0d_data", i), rdata, tbl[i].exp_d);
      chk($sformatf("vec%0d_mrden_cycles", i), 64'(rd_log.size() - mr0), 64'(tbl[i].exp_mr));
      chk($sformatf("vec%0d_mwren_cycles", i), 64'(wr_log.size() - mw0), 64'(tbl[i].exp_mw));
    end
    for (int i = 0; i < WPL; i++) begin
      chk($sformatf("cold_rd_addr%0d", i), 64'(rd_log[rb0+i]), 64'(32'h100 + 8*i));
      chk($sformatf("evict_wr_addr%0d", i), 64'(wr_log[wb4+i]), 64'(32'h100 + 8*i));
      chk($sformatf("evict_rd_addr%0d", i), 64'(rd_log[rb4+i]), 64'(32'h500 + 8*i));
    end
    chk("evicted_word", mem_rd(32'h100), 64'h00000000_55667788);

    // ---- two dirty lines then flush ----
    ew = ref_access(32'h100, 1'b1);
    do_req(32'h100, 1'b0, 8'hF0, 64'hCAFEBABE_00000000, rdata, wcyc, done, wt);
    chk("dirty1_wait", 64'(wcyc), 64'(ew));
    ew = ref_access(32'h200, 1'b1);
    do_req(32'h200, 1'b0, 8'hFF, 64'h0123456789ABCDEF, rdata, wcyc, done, wt);
    chk("dirty2_wait", 64'(wcyc), 64'(ew));
    do_flush(seen, nmw);
    ref_clear();
    chk("flush_done_seen", 64'(seen), 1);
    chk("flush_mwren_cycles", 64'(nmw), 8);
    chk("flush_mem_100", mem_rd(32'h100), view_rd(32'h100));
    chk("flush_mem_200", mem_rd(32'h200), view_rd(32'h200));
    ew = ref_access(32'h100, 1'b0);
    do_req(32'h100, 1'b1, 8'h00, 64'h0, rdata, wcyc, done, wt);
    chk("post_flush_wait", 64'(wcyc), 6);
    chk("post_flush_data", rdata, 64'hCAFEBABE_55667788);

    // ---- reset during the second FILL cycle ----
    mw0 = wr_log.size();
    bus.address = 32'h300; bus.rd = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("prerst_mrden", 64'(bus.mrden), 1);
    chk("prerst_rd_addr", 64'(bus.m_rd_address), 64'h308);
    rst = 1'b1; bus.rd = 1'b0;
    #1;
    chk_zero("midfill_rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    ref_clear();
    chk("rst_no_mem_write", 64'(wr_log.size() - mw0), 0);
    mr0 = rd_log.size();
    ew = ref_access(32'h300, 1'b0);
    do_req(32'h300, 1'b1, 8'h00, 64'h0, rdata, wcyc, done, wt);
    chk("reload_wait", 64'(wcyc), 64'(ew));
    chk("reload_data", rdata, view_rd(32'h300));
    chk("reload_mrden_cycles", 64'(rd_log.size() - mr0), 4);
    for (int i = 0; i < WPL; i++)
      chk($sformatf("reload_rd_addr%0d", i), 64'(rd_log[mr0+i]), 64'(32'h300 + 8*i));

    // ---- random traffic ----
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        ew = WPL * ref_dirty_lines();
        do_flush(seen, nmw);
        ref_clear();
        chk($sformatf("rnd%0d_flush_seen", n), 64'(seen), 1);
        chk($sformatf("rnd%0d_flush_writes", n), 64'(nmw), 64'(ew));
      end
      a  = 32'($urandom_range(0, 511)) * 32'd8;
      ld = 1'($urandom_range(0, 1));
      be = 8'($urandom_range(1, 255));
      d  = {$urandom, $urandom};
      ew = ref_access(a, !ld);
      rdata = view_rd(a);
      do_req(a, ld, be, d, rdata, wcyc, done, wt);
      chk($sformatf("rnd%0d_wait a=%h", n, a), 64'(wcyc), 64'(ew));
      chk($sformatf("rnd%0d_ready", n), 64'(done), 1);
      if (ld) chk($sformatf("rnd%0d_data a=%h", n, a), rdata, view_rd(a));
    end

    // ---- final flush: backing memory must match the CPU view ----
    ew = WPL * ref_dirty_lines();
    do_flush(seen, nmw);
    ref_clear();
    chk("final_flush_writes", 64'(nmw), 64'(ew));
    foreach (view[k]) chk($sformatf("final_mem a=%h", k), mem_rd(k), view[k]);
    chk("rd_wr_never_together", 64'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_wb_param.md
Name: dcache_wb_param

Overview:
- Parametrised write-back, write-allocate, direct-mapped data cache; next generation of the pipeline's data cache.
- Sits between the M stage (`alu_out_M`, `rs2_data_M`, `M_dm_w_en`, read strobe) and the data memory model.
- Line count and line length are configurable.
- Adds burst line fill, dirty-line eviction, a software-triggered flush walk and a fixed-latency memory interface.

Parameters:
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 64, CPU/memory word width; a power of two, at least 32.
- `NUM_LINES`, 16, number of lines; a power of two.
- `WORDS_PER_LINE`, 4, words per line; a power of two, at least 2.
- `MEM_RD_LAT`, 1, cycles from `mrden` to `data_in_mem` valid; at least 1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `address` in `ADDR_W`: CPU byte address.
- `data_in_cpu` in `DATA_W`: CPU store data.
- `rd` in 1: load request.
- `wr` in `DATA_W/8`: store byte enables; nonzero means store.
- `flush` in 1: request writeback and invalidate of the whole cache.
- `data2cpu` out `DATA_W`: load data.
- `data_ready` out 1: request completes this cycle.
- `waiting` out 1: pipeline must hold all stages.
- `flush_done` out 1: one-cycle pulse at the end of a flush.
- `m_rd_address` out `ADDR_W`: memory read address, word aligned.
- `mrden` out 1: memory read strobe.
- `data_in_mem` in `DATA_W`: memory read data.
- `m_wr_address` out `ADDR_W`: memory write address.
- `mwren` out `DATA_W/8`: memory byte write enables.
- `data2mem` out `DATA_W`: memory write data.

Behaviour:
- Address split:
  - `OFF = log2(DATA_W/8)`.
  - `WOFF = log2(WORDS_PER_LINE)`.
  - `IDX = log2(NUM_LINES)`.
  - Tag is the remaining upper bits.
  - Low `OFF` bits are ignored; accesses are word aligned.
- Storage per line: valid, dirty, tag, `WORDS_PER_LINE` data words.
- Reset:
  - All valid and dirty bits cleared; FSM to IDLE.
  - All outputs 0.
  - Reset mid-fill or mid-writeback abandons the operation immediately, with no partial memory write after reset deasserts.
- FSM states: IDLE, WB, FILL, DONE, FLUSH.
- IDLE, read hit:
  - `data2cpu` = stored word, combinational.
  - `data_ready=1`, `waiting=0`, same cycle.
- IDLE, write hit:
  - Bytes with `wr[i]=1` merged at the clock edge; dirty set.
  - `data_ready=1`, `waiting=0`.
- IDLE, miss:
  - `waiting=1` combinationally the same cycle.
  - Victim valid and dirty → WB; otherwise → FILL.
- WB:
  - `WORDS_PER_LINE` consecutive cycles.
  - `mwren` all ones; `m_wr_address` = victim line base + i·(`DATA_W/8`); `data2mem` = word i.
  - Then → FILL.
- FILL:
  - Issues `WORDS_PER_LINE` reads on consecutive cycles: `mrden=1`, `m_rd_address` = new line base + i·(`DATA_W/8`).
  - Captures `data_in_mem` `MEM_RD_LAT` cycles after each issue.
  - After the last capture: tag written, valid=1, dirty=0 → DONE.
- DONE:
  - Replays the held request as a hit: load returns data; store merges and sets dirty.
  - `data_ready=1`, `waiting=0` for exactly one cycle → IDLE.
- Miss latency:
  - Clean victim: `WORDS_PER_LINE + MEM_RD_LAT + 1` cycles of `waiting`.
  - Dirty victim: add `WORDS_PER_LINE` cycles.
- CPU inputs are held stable by the CPU while `waiting=1`; the cache does not re-sample them.
- `rd` and nonzero `wr` together: treated as a store; `data2cpu` undefined.
- `flush`:
  - Sampled only in IDLE with no request, or in IDLE with a request present; a pending request is serviced first.
  - FLUSH walks line 0 to `NUM_LINES-1`.
  - A dirty valid line is written back as in WB, then invalidated.
  - A clean line is invalidated in one cycle.
  - `waiting=1` throughout.
  - `flush_done` pulses one cycle after the last line → IDLE.
- `mrden` and `mwren` are never asserted in the same cycle.
- Outside completion cycles: `data_ready=0`; `data2cpu` holds its last value.

Optional Feature:
- Macro: `DCACHE_PERF_CNT_EN`.
- With the macro:
  - Output ports `hit_cnt`, `miss_cnt`, `wb_cnt`, each 32 bits.
  - Each counter saturates at `0xFFFFFFFF`; all cleared by `rst`.
  - `hit_cnt` increments on IDLE hits.
  - `miss_cnt` increments on IDLE→WB/FILL transitions.
  - `wb_cnt` increments once per line written back, including during flush.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Cold load at `0x100` after reset, mem[`0x100`]=`0xA5`, defaults → `waiting` high for 6 cycles, then `data_ready=1`, `data2cpu=0xA5`. Reads issued at `0x100`, `0x108`, `0x110`, `0x118`.
- Load `0x108` right after the previous fill → `data_ready=1` the same cycle, `waiting=0`, no `mrden`.
- Store `wr=0x0F` data `0x1122334455667788` to `0x100`, then load `0x100` → returns the upper 4 bytes of the old data merged with `0x55667788` in the low 4 bytes.
- Dirty `0x100`, then load `0x500` (same index) → 4 writes to `0x100..0x118` first, then 4 reads; `waiting` high for 10 cycles. Memory `0x100` holds the merged word.
- Two dirty lines, `flush` → exactly 8 `mwren` cycles, `flush_done` pulse. A subsequent load to `0x100` misses.
- `rst` asserted during the second FILL cycle → all outputs 0 immediately. Re-load of the same address misses and refetches all 4 words.
